// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Purpose  : Shared glyph, anode and code constants for the 4-digit scanner.
// Revision : 1.0
// ============================================================================
package seven_seg_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_DASH  = 7'h3F;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    localparam logic [3:0] DIGIT_OFF      = 4'b1111;
    localparam logic [3:0] CODE_ZERO      = 4'h0;
    localparam logic [3:0] CODE_DASH      = 4'hA;
    localparam logic [3:0] CODE_BLANK_MIN = 4'hB;
    localparam logic [3:0] CODE_BLANK     = 4'hF;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/seven_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_decoder
// Purpose  : Combinational 4-bit code to active-low seven-segment glyph.
// Revision : 1.0
// ============================================================================
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = GLYPH_BLANK;
        case (code_i)
            4'h0:      glyph_o = GLYPH_0;
            4'h1:      glyph_o = GLYPH_1;
            4'h2:      glyph_o = GLYPH_2;
            4'h3:      glyph_o = GLYPH_3;
            4'h4:      glyph_o = GLYPH_4;
            4'h5:      glyph_o = GLYPH_5;
            4'h6:      glyph_o = GLYPH_6;
            4'h7:      glyph_o = GLYPH_7;
            4'h8:      glyph_o = GLYPH_8;
            4'h9:      glyph_o = GLYPH_9;
            CODE_DASH: glyph_o = GLYPH_DASH;
            default:   glyph_o = GLYPH_BLANK;
        endcase
    end

endmodule : seven_seg_decoder
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan
// Purpose  : Time-multiplexed 4-digit common-anode seven-segment driver.
//            Optional: SEVSEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision : 1.0
// ============================================================================
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int SCAN_BITS = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] nums,
    output logic [6:0]  display,
    output logic [3:0]  digit
);

    logic [SCAN_BITS-1:0] count_q;
    logic [SCAN_BITS-1:0] count_d;
    logic [3:0]           digit_q;
    logic [3:0]           digit_d;
    logic [6:0]           display_q;
    logic [6:0]           display_d;

    logic [1:0]           w_sel;
    logic [3:0]           w_code;
    logic [3:0]           w_dec_code;
    logic [6:0]           w_glyph;

    assign w_sel  = count_q[SCAN_BITS-1 -: 2];
    assign w_code = nums[{w_sel, 2'b00} +: 4];

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    logic [3:0] w_lead;
    logic       w_higher_ok;
    logic [3:0] w_cur;

    // A digit is a leading zero when it is 0 and everything above it is 0 or blank.
    always_comb begin
        w_lead      = 4'b0000;
        w_higher_ok = 1'b1;
        w_cur       = 4'h0;
        for (int i = 3; i >= 1; i--) begin
            w_cur = nums[i*4 +: 4];
            if (w_cur == CODE_ZERO && w_higher_ok) begin
                w_lead[i] = 1'b1;
            end
            w_higher_ok = w_higher_ok &&
                          ((w_cur == CODE_ZERO) || (w_cur >= CODE_BLANK_MIN));
        end
    end

    assign w_dec_code = w_lead[w_sel] ? CODE_BLANK : w_code;
`else
    assign w_dec_code = w_code;
`endif

    seven_seg_decoder u_decoder (
        .code_i  (w_dec_code),
        .glyph_o (w_glyph)
    );

    always_comb begin
        count_d   = count_q + {{(SCAN_BITS-1){1'b0}}, 1'b1};
        digit_d   = ~(4'b0001 << w_sel);
        display_d = w_glyph;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= '0;
            digit_q   <= DIGIT_OFF;
            display_q <= GLYPH_BLANK;
        end else begin
            count_q   <= count_d;
            digit_q   <= digit_d;
            display_q <= display_d;
        end
    end

    assign digit   = digit_q;
    assign display = display_q;

endmodule : seven_seg_scan
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan
// Purpose  : Self-checking bench for seven_seg_scan with SCAN_BITS = 4.
// Revision : 1.0
// ============================================================================
module tb_seven_seg_scan;

    logic        clk;
    logic        rst;
    logic [15:0] nums;
    logic [6:0]  display;
    logic [3:0]  digit;

    int n_tests;
    int n_fail;
    int model_cnt;
    logic [6:0] gl [16];

    typedef struct {
        logic [15:0]     n;
        logic [3:0][6:0] g;
    } vec_t;
    vec_t tbl [5];

    seven_seg_scan #(.SCAN_BITS(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .nums    (nums),
        .display (display),
        .digit   (digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] model_glyph(input logic [15:0] n, input int idx);
        int code;
        code = int'((n >> (4 * idx)) & 16'hF);
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        if (idx > 0 && code == 0) begin
            bit all_lead;
            all_lead = 1'b1;
            for (int j = idx + 1; j < 4; j++) begin
                int c;
                c = int'((n >> (4 * j)) & 16'hF);
                if (!(c == 0 || c >= 11)) all_lead = 1'b0;
            end
            if (all_lead) return 7'h7F;
        end
`endif
        return gl[code];
    endfunction

    task automatic check(input string name, input logic [3:0] exp_d, input logic [6:0] exp_g);
        n_tests++;
        if (digit !== exp_d) begin
            n_fail++;
            $display("FAIL %s digit: got %b expected %b at %0t", name, digit, exp_d, $time);
        end
        n_tests++;
        if (display !== exp_g) begin
            n_fail++;
            $display("FAIL %s display: got %h expected %h at %0t", name, display, exp_g, $time);
        end
    endtask

    // One rising edge: model predicts from pre-edge state, compare 1 time unit later.
    task automatic tick(input string name);
        logic [3:0] ed;
        logic [6:0] eg;
        int idx;
        @(posedge clk);
        if (!rst) begin
            ed = 4'b1111;
            eg = 7'h7F;
            model_cnt = 0;
        end else begin
            idx = (model_cnt / 4) % 4;
            ed  = 4'hF ^ (4'b0001 << idx);
            eg  = model_glyph(nums, idx);
            model_cnt = (model_cnt + 1) % 16;
        end
        #1;
        check(name, ed, eg);
    endtask

    task automatic async_reset();
        rst = 1'b0;
        model_cnt = 0;
        #1;
        check("async_rst", 4'b1111, 7'h7F);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_cnt = 0;
        gl[0] = 7'h40; gl[1] = 7'h79; gl[2] = 7'h24; gl[3] = 7'h30;
        gl[4] = 7'h19; gl[5] = 7'h12; gl[6] = 7'h02; gl[7] = 7'h78;
        gl[8] = 7'h00; gl[9] = 7'h10; gl[10] = 7'h3F;
        for (int i = 11; i < 16; i++) gl[i] = 7'h7F;

        tbl[0].n = 16'h1234; tbl[0].g = {7'h79, 7'h24, 7'h30, 7'h19};
        tbl[2].n = 16'hA98A; tbl[2].g = {7'h3F, 7'h10, 7'h00, 7'h3F};
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
        tbl[1].n = 16'hFF05; tbl[1].g = {7'h7F, 7'h7F, 7'h7F, 7'h12};
        tbl[3].n = 16'h0030; tbl[3].g = {7'h7F, 7'h7F, 7'h30, 7'h40};
        tbl[4].n = 16'h0000; tbl[4].g = {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
        tbl[1].n = 16'hFF05; tbl[1].g = {7'h7F, 7'h7F, 7'h40, 7'h12};
        tbl[3].n = 16'h0030; tbl[3].g = {7'h40, 7'h40, 7'h30, 7'h40};
        tbl[4].n = 16'h0000; tbl[4].g = {7'h40, 7'h40, 7'h40, 7'h40};
`endif

        // Held in reset while clocking
        rst  = 1'b0;
        nums = 16'h1234;
        for (int i = 0; i < 3; i++) tick("hold_rst");

        // Table-driven scans, each entered from a mid-scan reset
        for (int t = 0; t < 5; t++) begin
            nums = tbl[t].n;
            rst  = 1'b1;
            for (int k = 0; k < 6; k++) @(posedge clk);
            #1;
            async_reset();
            @(posedge clk);
            #1;
            rst = 1'b1;
            for (int k = 0; k < 20; k++) begin
                int idx;
                idx = (k / 4) % 4;
                @(posedge clk);
                #1;
                check($sformatf("tbl%0d_edge%0d", t, k),
                      4'hF ^ (4'b0001 << idx), tbl[t].g[idx]);
            end
        end

        // Mid-slot nums change shows exactly one edge later
        async_reset();
        nums = 16'h0000;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midslot_before", 4'b1110, 7'h40);
        nums = 16'h0007;
        @(posedge clk);
        #1;
        check("midslot_after", 4'b1110, 7'h78);

        // Randomized run against the reference model
        async_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) nums = 16'($urandom);
            if (rst && $urandom_range(0, 60) == 0) async_reset();
            else if (!rst && $urandom_range(0, 1) == 0) rst = 1'b1;
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seven_seg_scan
`default_nettype wire

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Time-multiplexed driver for a 4-digit common-anode seven-segment display.
- Takes four 4-bit codes packed in nums and scans them onto one shared active-low segment bus.
- Each digit is enabled in turn through an active-low one-hot anode bus.
- Sits under the display top level; the upper two codes are driven 4'hF to blank those digits.

Parameters:
- SCAN_BITS, 17, width of the free-running scan counter; the top 2 bits select the digit. Each digit is shown for 2^(SCAN_BITS-2) clocks (327.68 us at 100 MHz). Legal range 3..24.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- nums  input  16  four digit codes: nums[3:0] drives digit 0 (rightmost), up to nums[15:12] for digit 3 (leftmost).
- display  output  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit).
- digit  output  4  anode enables, active-low one-hot; bit i enables digit i.

Behaviour:
- Reset (rst=0, asynchronous):
  - scan counter = 0.
  - digit = 4'b1111 (all off).
  - display = 7'h7F (all segments off).
- Counter:
  - increments by 1 every clk while rst=1.
  - wraps from 2^SCAN_BITS-1 to 0.
  - sel = counter[SCAN_BITS-1:SCAN_BITS-2].
- Registered outputs, updated every clk from the pre-edge sel and nums. One-cycle latency from a sel or nums change to the outputs.
  - digit <= ~(4'b0001 << sel).
  - display <= glyph(nums[4*sel +: 4]).
- Glyph map (active-low, {g..a}):
  - 0: 7'h40, 1: 7'h79, 2: 7'h24, 3: 7'h30, 4: 7'h19
  - 5: 7'h12, 6: 7'h02, 7: 7'h78, 8: 7'h00, 9: 7'h10
  - 10: 7'h3F (dash)
  - 11..15: 7'h7F (blank)
- Scan order: digit 0, 1, 2, 3, 0, ... Exactly one anode is low at any time after the first post-reset edge.
- nums is sampled every clock with no internal hold. A change mid-slot appears on the next edge.
- Reset asserted mid-scan: outputs blank immediately. After release, scan restarts at digit 0; the first edge drives digit=4'b1110.
- No handshake, no other outputs.

Optional Feature:
- Macro: SEVSEG_LEADING_ZERO_BLANK_EN.
- Defined: a digit i in 1..3 is forced blank (7'h7F) when its code is 0 and every higher digit is either 0 or a blank code (11..15). Digit 0 is never suppressed. Anode timing is unchanged.
- Not defined: every code renders per the glyph map, including leading zeros.

Decomposition:
- Package seven_seg_pkg:
  - glyph constants (GLYPH_0..GLYPH_9, GLYPH_DASH, GLYPH_BLANK).
  - DIGIT_OFF = 4'b1111.
  - code constant CODE_DASH = 4'hA.
- One combinational sub-module, seven_seg_decoder: 4-bit code in, 7-bit active-low glyph out.
- Counter, select and output registers stay in seven_seg_scan.

Test Plan (SCAN_BITS=4, so 4 clocks per digit):
- Hold rst=0 and toggle clk -> digit=4'b1111, display=7'h7F throughout. Assert rst mid-scan -> outputs blank asynchronously, before the next edge.
- Release rst with nums=16'h1234 -> successive 4-clock slots show:
  - digit=1110 / display=7'h19
  - digit=1101 / 7'h30
  - digit=1011 / 7'h24
  - digit=0111 / 7'h79
  - then the sequence repeats from digit 0.
- nums=16'hFF05 -> digits 3,2 blank (7'h7F), digit 1 = 7'h40, digit 0 = 7'h12. Anodes still cycle through all four.
- nums=16'hA98A -> dash on digits 3 and 0, 7'h10 on digit 2, 7'h00 on digit 1.
- Change nums from 16'h0000 to 16'h0007 mid-slot of digit 0 -> display changes 7'h40 to 7'h78 exactly one clock later.
- With SEVSEG_LEADING_ZERO_BLANK_EN defined:
  - nums=16'h0030 -> digits 3,2 blank, digit 1 = 7'h30, digit 0 = 7'h40.
  - nums=16'h0000 -> only digit 0 lit (7'h40).
